// File: rtl/io_mem_streamer.sv
// Read-only burst streamer: fetches word_count words from a combinational RAM and streams them
// over a valid/ready port. Optional running checksum enabled by IO_STREAM_CHECKSUM_EN.
module io_mem_streamer #(
    parameter int unsigned COUNT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic [31:0]        mem_A,
    output logic               mem_WE,
    input  logic [31:0]        mem_RD,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        checksum
);

    typedef enum logic [1:0] {StIdle, StFetch, StStream, StDone} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               accept;
    logic               handshake;

    assign accept    = (state_q == StIdle) && start && (base_addr[1:0] == 2'b00);
    assign handshake = (state_q == StStream) && valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (base_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (word_count == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = word_count;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                data_d  = mem_RD;
                valid_d = 1'b1;
                addr_d  = addr_q + 32'd4;
                rem_d   = rem_q - COUNT_W'(1);
                state_d = StStream;
            end
            StStream: begin
                if (handshake) begin
                    // rem_q counts words not yet fetched; zero means the presented word is the last
                    if (rem_q != '0) begin
                        data_d = mem_RD;
                        addr_d = addr_q + 32'd4;
                        rem_d  = rem_q - COUNT_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef IO_STREAM_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (handshake) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_cfg;
    assign unused_cfg = accept;
    assign checksum   = '0;
`endif

    assign mem_A     = addr_q;
    assign mem_WE    = 1'b0;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: tb/tb_io_mem_streamer.sv
// Scoreboard bench for io_mem_streamer: expected words queued at issue, checked by a monitor
// whenever out_valid is high. Define IO_STREAM_CHECKSUM_EN to check the checksum build.
module tb_io_mem_streamer;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [31:0]   mem_A, mem_RD, out_data, checksum;
    logic          mem_WE, out_valid, busy, done, err;
    logic          out_ready = 1'b1;

    logic [31:0] ram_key = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sum = '0;
    logic [31:0] last_addr = '0;
    int          checks = 0, errors = 0;
    int          done_cnt = 0, err_cnt = 0;
    int          ready_mode = 0, pidx = 0;
    logic        pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // RAM word at byte address a is 0x100 + a/4, optionally scrambled per burst
    assign mem_RD = (32'h100 + (mem_A >> 2)) ^ ram_key;

    io_mem_streamer #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no valid", out_data);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("checksum", checksum, exp_sum);
            end
            if (err) err_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = pat[pidx % 5];
                pidx++;
            end
        endcase
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_mem_A"}, mem_A, 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_checksum"}, checksum, 32'h0);
    endtask

    task automatic load_expect(input logic [31:0] base, input int cnt, input logic [31:0] key);
        logic [31:0] sum;
        logic [31:0] a;
        logic [31:0] w;
        sum = '0;
        for (int j = 0; j < cnt; j++) begin
            a = base + 32'(4 * j);
            w = (32'h100 + (a >> 2)) ^ key;
            exp_q.push_back(w);
            sum = sum + w;
        end
`ifdef IO_STREAM_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
    endtask

    task automatic run_burst(input logic [31:0] base, input int cnt, input int mode,
                             input logic [31:0] key, input bit mid, input bit lat);
        int d0;
        int cyc;
        ram_key    = key;
        ready_mode = mode;
        pidx       = 0;
        if (mode == 0) out_ready = 1'b1;
        load_expect(base, cnt, key);
        d0 = done_cnt;
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = CW'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 300) begin
            cyc++;
            if (mid && cyc == 2) begin
                start      = 1'b1;
                base_addr  = 32'h40;
                word_count = CW'(7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (lat) check("busy_cycles", 32'(cyc), (cnt == 0) ? 32'd1 : 32'(cnt + 2));
        else     check("burst_finished", 32'(busy), 32'h0);
        check("done_pulses", 32'(done_cnt), 32'(d0 + 1));
        check("words_left", 32'(exp_q.size()), 32'h0);
        check("mem_WE", 32'(mem_WE), 32'h0);
        if (cnt > 0) last_addr = base + 32'(4 * cnt);
        check("final_addr", mem_A, last_addr);
    endtask

    task automatic bad_start(input logic [31:0] base);
        int e0;
        e0 = err_cnt;
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = CW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", 32'(err), 32'h1);
        check("err_busy", 32'(busy), 32'h0);
        check("err_mem_A", mem_A, last_addr);
        @(posedge clk); #1;
        check("err_cleared", 32'(err), 32'h0);
        check("err_count", 32'(err_cnt), 32'(e0 + 1));
        check("err_idle", 32'(busy), 32'h0);
    endtask

    task automatic reset_mid_burst();
        int d0;
        int cyc;
        ram_key    = '0;
        ready_mode = 0;
        out_ready  = 1'b1;
        load_expect(32'h0, 5, 32'h0);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 32'h0;
        word_count = CW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (exp_q.size() > 4 && cyc < 50) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("reach_second_word", 32'(exp_q.size()), 32'd4);
        #2;
        rst_n = 1'b0;
        d0    = done_cnt;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_sum   = '0;
        last_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("no_done_after_reset", 32'(done_cnt), 32'(d0));
        run_burst(32'h20, 1, 0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_burst(32'h10, 4, 0, 32'h0, 1'b0, 1'b1);
        run_burst(32'h0, 3, 2, 32'h0, 1'b0, 1'b0);
        bad_start(32'h6);
        run_burst(32'h8, 0, 0, 32'h0, 1'b0, 1'b1);
        reset_mid_burst();
        run_burst(32'h100, 6, 0, 32'h0, 1'b1, 1'b1);
        run_burst(32'hFFFF_FFF0, 8, 1, $urandom, 1'b0, 1'b0);
        bad_start(32'h13);

        for (int i = 0; i < 20; i++) begin
            run_burst($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 2)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
